// File: rtl/cfdl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cfdl_pkg
//  Description : Shared constants and state encoding for the comb-filter
//                delay-line controller.
//  Revision    : 1.0  initial release
// ============================================================================
package cfdl_pkg;

  localparam int CFDL_AW   = 10;
  localparam int CFDL_DW   = 18;
  localparam int MIN_DELAY = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_CLEAR = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/cfdl_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : cfdl_ctrl
//  Description : Sequencer for a single-port write-first 2**AW x DW block RAM
//                used as a circular comb-filter delay line. Each accepted
//                sample reads the tap written eff_delay samples earlier, then
//                stores the new sample at the write pointer (3 cycles/sample).
//                Optional macro CFDL_CLEAR_EN: after every reset the RAM is
//                swept with zeros before the first sample is accepted.
//  Revision    : 1.0  initial release
// ============================================================================
module cfdl_ctrl
  import cfdl_pkg::*;
#(
  parameter int AW = CFDL_AW,
  parameter int DW = CFDL_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic [AW-1:0] delay,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  output logic          ram_we,
  input  logic [DW-1:0] ram_dout
);

`ifdef CFDL_CLEAR_EN
  localparam state_t c_rst_state = ST_CLEAR;
  localparam logic   c_rst_ready = 1'b0;
`else
  localparam state_t c_rst_state = ST_IDLE;
  localparam logic   c_rst_ready = 1'b1;
`endif

  state_t        r_state;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] w_eff_delay;
  logic [AW-1:0] w_rd_addr;

  // A zero delay would read the slot about to be written; clamp it to one.
  assign w_eff_delay = (delay == '0) ? AW'(MIN_DELAY) : delay;
  // Natural AW-bit wrap gives the modulo-depth circular read address.
  assign w_rd_addr   = r_wr_ptr - w_eff_delay;

  // Read/write sequencer: address, write strobe, handshake and output regs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= c_rst_state;
      r_wr_ptr  <= '0;
      ram_addr  <= '0;
      ram_din   <= '0;
      ram_we    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      in_ready  <= c_rst_ready;
    end else begin
      out_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            ram_din  <= in_data;
            ram_addr <= w_rd_addr;
            ram_we   <= 1'b0;
            in_ready <= 1'b0;
            r_state  <= ST_READ;
          end
        end
        ST_READ: begin
          // RAM has latched the tap address; now point at the write slot.
          ram_addr <= r_wr_ptr;
          ram_we   <= 1'b1;
          r_state  <= ST_WRITE;
        end
        ST_WRITE: begin
          // ram_dout still holds the tap read; the write-first echo of the
          // new sample only appears after this edge.
          out_data  <= ram_dout;
          out_valid <= 1'b1;
          ram_we    <= 1'b0;
          r_wr_ptr  <= r_wr_ptr + 1'b1;
          in_ready  <= 1'b1;
          r_state   <= ST_IDLE;
        end
        ST_CLEAR: begin
`ifdef CFDL_CLEAR_EN
          // First cycle raises the strobe at address 0, then one address per
          // cycle; the cycle writing the last address hands over to IDLE.
          ram_din <= '0;
          if (!ram_we) begin
            ram_we <= 1'b1;
          end else if (ram_addr == {AW{1'b1}}) begin
            ram_we   <= 1'b0;
            ram_addr <= '0;
            r_wr_ptr <= '0;
            in_ready <= 1'b1;
            r_state  <= ST_IDLE;
          end else begin
            ram_addr <= ram_addr + 1'b1;
          end
`else
          r_state  <= ST_IDLE;
          in_ready <= 1'b1;
`endif
        end
        default: begin
          r_state  <= ST_IDLE;
          ram_we   <= 1'b0;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cfdl_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cfdl_ctrl
//  Description : Self-checking bench for cfdl_ctrl with a behavioural 1024x18
//                write-first RAM behind the ram_* port and a scoreboard model
//                of the delay line.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cfdl_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [17:0] in_data = '0;
  logic [9:0]  delay = '0;
  logic        out_valid;
  logic [17:0] out_data;
  logic [9:0]  ram_addr;
  logic [17:0] ram_din;
  logic        ram_we;
  logic [17:0] ram_dout;

  cfdl_ctrl #(.AW(10), .DW(18)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .delay    (delay),
    .out_valid(out_valid),
    .out_data (out_data),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_we   (ram_we),
    .ram_dout (ram_dout)
  );

  always #5 clk = ~clk;

  // Behavioural single-port write-first block RAM.
  logic [17:0] mem [0:1023];
  initial begin
    for (int i = 0; i < 1024; i++) begin
`ifdef CFDL_CLEAR_EN
      mem[i] = 18'h2AAAA;
`else
      mem[i] = 18'h0;
`endif
    end
  end
  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr] <= ram_din;
      ram_dout      <= ram_din;
    end else begin
      ram_dout <= mem[ram_addr];
    end
  end

  // Reference model state.
  typedef struct {
    logic [17:0] exp_out;
    logic [9:0]  raddr;
    logic [9:0]  waddr;
    logic [17:0] wdata;
    int          acc;
  } sb_t;

  sb_t         sbq[$];
  logic [17:0] ref_mem [0:1023];
  logic [9:0]  ref_ptr = '0;
  logic [17:0] outs[$];
  logic [17:0] last_out = '0;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  int          n_acc = 0;
  int          n_writes = 0;
  bit          sweeping = 1'b1;

  initial begin
    for (int i = 0; i < 1024; i++) begin
`ifdef CFDL_CLEAR_EN
      ref_mem[i] = 18'h2AAAA;
`else
      ref_mem[i] = 18'h0;
`endif
    end
  end

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Scoreboard: observe accepts, RAM accesses and outputs at the falling edge.
  sb_t        m_e;
  logic [9:0] m_eff;
  always @(negedge clk) begin
    if (rst_n && !sweeping) begin
      if (ram_we) n_writes++;
      if (sbq.size() > 0) begin
        if (cyc == sbq[0].acc + 1) begin
          check("rd_addr", ram_addr, sbq[0].raddr);
          check("rd_we", ram_we, 1'b0);
        end
        if (cyc == sbq[0].acc + 2) begin
          check("wr_addr", ram_addr, sbq[0].waddr);
          check("wr_we", ram_we, 1'b1);
          check("wr_din", ram_din, sbq[0].wdata);
        end
      end
      if (out_valid) begin
        check("ov_expected", sbq.size(), 1);
        if (sbq.size() > 0) begin
          m_e = sbq.pop_front();
          check("out_data", out_data, m_e.exp_out);
          check("latency", cyc - m_e.acc, 3);
          ref_mem[m_e.waddr] = m_e.wdata;
          ref_ptr  = m_e.waddr + 10'd1;
          last_out = out_data;
          outs.push_back(out_data);
        end
      end else if (sbq.size() > 0 && cyc > sbq[0].acc + 3) begin
        check("ov_timeout", out_valid, 1'b1);
        void'(sbq.pop_front());
      end
      if (in_valid && in_ready) begin
        m_eff       = (delay == 10'd0) ? 10'd1 : delay;
        m_e.raddr   = ref_ptr - m_eff;
        m_e.waddr   = ref_ptr;
        m_e.wdata   = in_data;
        m_e.exp_out = ref_mem[m_e.raddr];
        m_e.acc     = cyc;
        sbq.push_back(m_e);
        n_acc++;
      end
    end
  end

  // Asserts reset at once (wherever the FSM is), checks reset values, releases.
  task automatic do_reset();
    int n;
    rst_n    = 1'b0;
    sweeping = 1'b1;
    in_valid = 1'b0;
    sbq.delete();
    ref_ptr  = '0;
    #1;
    check("rst_we", ram_we, 1'b0);
    check("rst_ov", out_valid, 1'b0);
    check("rst_addr", ram_addr, 10'd0);
    check("rst_din", ram_din, 18'd0);
    check("rst_out", out_data, 18'd0);
`ifdef CFDL_CLEAR_EN
    check("rst_ready", in_ready, 1'b0);
`else
    check("rst_ready", in_ready, 1'b1);
`endif
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
`ifdef CFDL_CLEAR_EN
    n = 0;
    for (int t = 0; t < 1100; t++) begin
      @(negedge clk);
      if (in_ready) break;
      if (ram_we) begin
        check("clr_addr", ram_addr, n);
        check("clr_din", ram_din, 18'd0);
        n++;
      end
    end
    check("clr_count", n, 1024);
    check("clr_ready", in_ready, 1'b1);
    for (int i = 0; i < 1024; i++) ref_mem[i] = 18'h0;
`else
    n = 0;
    @(negedge clk);
    check("post_rst_ready", in_ready, 1'b1);
`endif
    @(posedge clk);
    #1 sweeping = 1'b0;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [17:0] d, input logic [9:0] dl);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data  = d;
    delay    = dl;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      t++;
      if (t > 20) begin
        check("accept_timeout", in_ready, 1'b1);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 18'($urandom);
    delay    = 10'($urandom);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sbq.size() > 0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("drain", sbq.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int acc0, wr0, start;
    bit acc;
    #3;
    do_reset();

`ifdef CFDL_CLEAR_EN
    // RAM was preloaded with 0x2AAAA; the sweep must leave silence.
    send(18'h00001, 10'd500);
    drain();
    check("clr_silence", last_out, 18'h0);
    do_reset();
`endif

    // Delay 3 over ten ascending samples.
    start = outs.size();
    for (int i = 1; i <= 10; i++) send(18'(i), 10'd3);
    drain();
    check("d3_first", outs[start], 18'h0);
    check("d3_fourth", outs[start + 3], 18'h1);
    check("d3_last", outs[start + 9], 18'h7);

    // Continuous in_valid: ready pattern 1,0,0 and one write per accept.
    acc0 = n_acc;
    wr0  = n_writes;
    in_valid = 1'b1;
    in_data  = 18'h100;
    delay    = 10'd4;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("hold_ready", in_ready, (i % 3 == 0));
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) in_data = in_data + 18'd1;
    end
    in_valid = 1'b0;
    drain();
    check("hold_accepts", n_acc - acc0, 4);
    check("hold_writes", n_writes - wr0, 4);

    // delay=0 clamps to one.
    send(18'h3FFFF, 10'd0);
    send(18'h12345, 10'd0);
    drain();
    check("clamp", last_out, 18'h3FFFF);

    // Maximum delay with pointer wrap.
    do_reset();
    start = outs.size();
    for (int i = 0; i < 1030; i++) send(18'(i), 10'd1023);
    drain();
    check("wrap_1025", outs[start + 1025], 18'd2);
    check("wrap_1022", outs[start + 1022], 18'd0);

    // Reset while in READ: in-flight sample discarded.
    send(18'h11111, 10'd5);
    do_reset();
    send(18'h22222, 10'd2);
    drain();
`ifndef CFDL_CLEAR_EN
    check("rst_read_tap", last_out, 18'd1022);
`endif

    // Reset while in WRITE: write strobe must drop before the edge.
    send(18'h33333, 10'd1);
    @(posedge clk);
    #1;
    check("we_pre", ram_we, 1'b1);
    do_reset();
    send(18'h04444, 10'd1);
    send(18'h05555, 10'd1);
    send(18'h06666, 10'd2);
    drain();
    check("rst_write_tap", last_out, 18'h04444);
`ifndef CFDL_CLEAR_EN
    check("discard_slot1", mem[1], 18'h05555);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", n_errors);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
